ucie_ctl_csr_regfile: RTL and testbench
=======================================

# ucie_ctl_csr_regfile

Adapter-side register file that sits directly downstream of the controller's logging write port and upstream of its CSR inputs. It takes hardware status/log writes (`a_wr`/`a_addr`/`a_wdata`) and a software register access port, and holds sticky RW1C error status, log, control and capability registers. It drives the retrain request and advertised-capability word back into the controller, and an error interrupt.

## Interface
Parameters:
- `ADVCAP_RST`, 32'h0000_0000, reset value of ADVCAP register
- `ERR_MASK_RST`, 32'hFFFF_FFFF, reset value of ERR_MASK (all masked)

Ports:
- `i_fdi_lclk`  in  1  clock (single clock domain)
- `i_rst_n`  in  1  asynchronous, active-low reset
- `i_a_wr`  in  1  hardware write strobe from logging FSM
- `i_a_addr`  in  8  hardware write byte address
- `i_a_wdata`  in  32  hardware write data
- `i_fdi_pl_state_sts`  in  4  current FDI state (Retrain = 4'b1011)
- `i_sw_wr`  in  1  software write strobe
- `i_sw_rd`  in  1  software read strobe
- `i_sw_addr`  in  8  software byte address
- `i_sw_wdata`  in  32  software write data
- `o_sw_rdata`  out  32  read data, valid with `o_sw_rvalid`
- `o_sw_rvalid`  out  1  one-cycle read-complete pulse
- `o_sw_err`  out  1  one-cycle error pulse (bad address, or rd+wr together)
- `o_CSR_UCIe_Link_Control_Retrain`  out  1  retrain request level
- `o_CSR_ADVCAP`  out  32  advertised capability word
- `o_irq`  out  1  OR of unmasked UNCORR/CORR status bits

## Operation
Register map (word-aligned; `addr[1:0]` ignored):
- 0x00 LINK_CTRL: bit0 RETRAIN (RW, HW-clear); bits 31:1 read 0.
- 0x04 LINK_STS: RO to SW; HW write overwrites. Bits 3:0 always read live `i_fdi_pl_state_sts`.
- 0x08 UNCORR_STS: HW write ORs data in (sticky); SW write-1-to-clear.
- 0x0C CORR_STS: same behaviour as UNCORR_STS.
- 0x10 HDR_LOG: HW write overwrites; SW RO.
- 0x14 ADVCAP: SW RW; HW writes ignored.
- 0x18 ERR_MASK: SW RW. Mask bit n=1 suppresses bit n of both STS registers from `o_irq`.
- 0x1C HW_DROP_CNT: 8-bit saturating count of HW writes to addresses other than 0x04/0x08/0x0C/0x10. SW write of any value clears it.

Rules:
- Other SW addresses: write dropped, read returns 0; `o_sw_err` pulses.
- `i_sw_wr` and `i_sw_rd` asserted together: neither is performed; `o_sw_err` pulses, `o_sw_rvalid` stays 0.
- RETRAIN: SW write of bit0=1 sets it and SW write of 0 clears it. HW clears it in the first cycle `i_fdi_pl_state_sts==4'b1011` is sampled; the HW clear beats a same-cycle SW set.
- Same-cycle HW set and SW RW1C on the same STS bit: the bit ends up 1 (set wins). Bits not written by either are unaffected.
- HW and SW write the same overwrite register (LINK_STS/HDR_LOG) in the same cycle: HW wins (SW cannot write these anyway).
- `o_CSR_ADVCAP` = ADVCAP register. `o_CSR_UCIe_Link_Control_Retrain` = RETRAIN bit. Both are registered outputs.
- `o_irq` = |(UNCORR_STS & ~ERR_MASK) | |(CORR_STS & ~ERR_MASK), registered.

## Timing
- Reset (async assert, sync deassert in the system) values: all STS/LOG/CNT registers 0, RETRAIN 0, ADVCAP=`ADVCAP_RST`, ERR_MASK=`ERR_MASK_RST`. All outputs 0 except `o_CSR_ADVCAP`=`ADVCAP_RST`.
- Writes (HW or SW) take effect at the clock edge where the strobe is sampled, and are visible to reads issued the following cycle.
- Read latency: 1 cycle. `o_sw_rdata`/`o_sw_rvalid` are registered; `o_sw_rdata` holds its last value when `o_sw_rvalid` is 0.
- `o_sw_err` asserts on the cycle after the offending strobe.
- `o_irq` updates 1 cycle after the STS or MASK change.
- Back-to-back accesses every cycle are supported with no stalls.
- HW_DROP_CNT saturates at 8'hFF. A SW clear and a HW drop in the same cycle give a result of 1.
- Reset mid-read: `o_sw_rvalid` is forced to 0 immediately (async).

## Structure
- Shared package `ucie_ctl_csr_pkg`: register address constants, FDI state encoding constants (RETRAIN=4'b1011), field bit positions.
- One sub-module, `ucie_ctl_csr_sticky32`: a 32-bit sticky register with an OR-set input and an RW1C input, where set wins on conflict. Instantiate it twice (UNCORR, CORR).
- Everything else is flat in the top module.

## Test plan
- Reset: check ADVCAP=`ADVCAP_RST`, mask all-ones, `o_irq`=0. Then SW read 0x14 → `o_sw_rvalid` on the next cycle with rdata=`ADVCAP_RST`.
- HW write 0x08 data 32'h5, then HW 0x08 data 32'h2 → UNCORR=32'h7. Write ERR_MASK 0 → `o_irq`=1. SW write 0x08 data 32'h7 → UNCORR=0, `o_irq`=0.
- Same cycle: HW set bit1 of 0x0C and SW RW1C 32'h2 on 0x0C → CORR bit1=1.
- SW write 0x00 with 1 → retrain=1. Drive `i_fdi_pl_state_sts`=4'b1011 → retrain=0 the next cycle. Repeat with a SW set in the same cycle as Retrain is sampled → result 0.
- SW read 0x40 → rdata 0 and `o_sw_err` pulse. SW rd+wr together on 0x14 → ADVCAP unchanged, err pulse, no rvalid.
- 300 HW writes to 0x20 → HW_DROP_CNT=8'hFF. SW clear in the same cycle as a HW drop → 1.

Source files
------------

// File: rtl/ucie_ctl_csr_pkg.sv
// Shared constants for the UCIe controller CSR register file: register word map,
// FDI state encodings and field positions.
package ucie_ctl_csr_pkg;

    localparam int unsigned ADDR_W  = 8;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned WORD_W  = 6;
    localparam int unsigned STATE_W = 4;
    localparam int unsigned CNT_W   = 8;

    // Word index (byte address [7:2]) of each register
    typedef enum logic [WORD_W-1:0] {
        REG_LINK_CTRL  = 6'h00,
        REG_LINK_STS   = 6'h01,
        REG_UNCORR_STS = 6'h02,
        REG_CORR_STS   = 6'h03,
        REG_HDR_LOG    = 6'h04,
        REG_ADVCAP     = 6'h05,
        REG_ERR_MASK   = 6'h06,
        REG_DROP_CNT   = 6'h07
    } csr_word_e;

    typedef enum logic [STATE_W-1:0] {
        FDI_RESET   = 4'b0000,
        FDI_ACTIVE  = 4'b0001,
        FDI_RETRAIN = 4'b1011
    } fdi_state_e;

    localparam int unsigned RETRAIN_BIT = 0;

    localparam logic [CNT_W-1:0] DROP_CNT_MAX = 8'hFF;

    function automatic logic [WORD_W-1:0] word_of(input logic [ADDR_W-1:0] addr);
        return addr[ADDR_W-1:ADDR_W-WORD_W];
    endfunction

endpackage

// File: rtl/ucie_ctl_csr_sticky32.sv
// 32-bit sticky status register: OR-set from hardware, write-1-to-clear from
// software, with set winning when both hit the same bit in one cycle.
module ucie_ctl_csr_sticky32
    import ucie_ctl_csr_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] set_bits,
    input  logic [DATA_W-1:0] clr_bits,
    output logic [DATA_W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else begin
            q <= (q & ~clr_bits) | set_bits;
        end
    end

endmodule

// File: rtl/ucie_ctl_csr_regfile.sv
// Adapter-side CSR file: sticky error status, logs, link control and capability
// registers shared between the logging write port and a software access port.
module ucie_ctl_csr_regfile
    import ucie_ctl_csr_pkg::*;
#(
    parameter logic [31:0] ADVCAP_RST   = 32'h0000_0000,
    parameter logic [31:0] ERR_MASK_RST = 32'hFFFF_FFFF
) (
    input  logic        i_fdi_lclk,
    input  logic        i_rst_n,
    input  logic        i_a_wr,
    input  logic [7:0]  i_a_addr,
    input  logic [31:0] i_a_wdata,
    input  logic [3:0]  i_fdi_pl_state_sts,
    input  logic        i_sw_wr,
    input  logic        i_sw_rd,
    input  logic [7:0]  i_sw_addr,
    input  logic [31:0] i_sw_wdata,
    output logic [31:0] o_sw_rdata,
    output logic        o_sw_rvalid,
    output logic        o_sw_err,
    output logic        o_CSR_UCIe_Link_Control_Retrain,
    output logic [31:0] o_CSR_ADVCAP,
    output logic        o_irq
);

    logic [WORD_W-1:0] hw_word;
    logic [WORD_W-1:0] sw_word;
    logic              sw_addr_ok;
    logic              sw_conflict;
    logic              sw_wr_ok;
    logic              sw_rd_ok;
    logic              hw_drop;
    logic              retrain_entry;
    logic [DATA_W-1:0] uncorr_set, uncorr_clr, corr_set, corr_clr;
    logic [DATA_W-1:0] uncorr_q, corr_q;
    logic [DATA_W-1:0] rd_mux;

    logic [DATA_W-STATE_W-1:0] link_sts_q;
    logic [DATA_W-1:0]         hdr_log_q;
    logic [DATA_W-1:0]         advcap_q;
    logic [DATA_W-1:0]         err_mask_q;
    logic [CNT_W-1:0]          drop_cnt_q;
    logic [STATE_W-1:0]        state_q;
    logic                      retrain_q;
    logic [DATA_W-1:0]         rdata_q;
    logic                      rvalid_q;
    logic                      err_q;
    logic                      irq_q;

    // Byte-lane bits of both addresses are don't-care in a word-aligned map
    logic unused_ok;
    assign unused_ok = ^{i_a_addr[1:0], i_sw_addr[1:0]};

    assign hw_word     = word_of(i_a_addr);
    assign sw_word     = word_of(i_sw_addr);
    assign sw_addr_ok  = (sw_word <= WORD_W'(REG_DROP_CNT));
    assign sw_conflict = i_sw_wr & i_sw_rd;
    assign sw_wr_ok    = i_sw_wr & ~i_sw_rd & sw_addr_ok;
    assign sw_rd_ok    = i_sw_rd & ~i_sw_wr;

    assign hw_drop = i_a_wr & ~((hw_word == REG_LINK_STS)   | (hw_word == REG_UNCORR_STS) |
                                (hw_word == REG_CORR_STS)   | (hw_word == REG_HDR_LOG));

    assign retrain_entry = (i_fdi_pl_state_sts == FDI_RETRAIN) && (state_q != FDI_RETRAIN);

    assign uncorr_set = (i_a_wr   && hw_word == REG_UNCORR_STS) ? i_a_wdata  : '0;
    assign uncorr_clr = (sw_wr_ok && sw_word == REG_UNCORR_STS) ? i_sw_wdata : '0;
    assign corr_set   = (i_a_wr   && hw_word == REG_CORR_STS)   ? i_a_wdata  : '0;
    assign corr_clr   = (sw_wr_ok && sw_word == REG_CORR_STS)   ? i_sw_wdata : '0;

    ucie_ctl_csr_sticky32 u_uncorr_sts (
        .clk      (i_fdi_lclk),
        .rst_n    (i_rst_n),
        .set_bits (uncorr_set),
        .clr_bits (uncorr_clr),
        .q        (uncorr_q)
    );

    ucie_ctl_csr_sticky32 u_corr_sts (
        .clk      (i_fdi_lclk),
        .rst_n    (i_rst_n),
        .set_bits (corr_set),
        .clr_bits (corr_clr),
        .q        (corr_q)
    );

    // HW-owned overwrite registers; SW has no write path to them
    always_ff @(posedge i_fdi_lclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            link_sts_q <= '0;
            hdr_log_q  <= '0;
        end else if (i_a_wr) begin
            if (hw_word == REG_LINK_STS) link_sts_q <= i_a_wdata[DATA_W-1:STATE_W];
            if (hw_word == REG_HDR_LOG)  hdr_log_q  <= i_a_wdata;
        end
    end

    // SW read/write registers
    always_ff @(posedge i_fdi_lclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            advcap_q   <= ADVCAP_RST;
            err_mask_q <= ERR_MASK_RST;
        end else if (sw_wr_ok) begin
            if (sw_word == REG_ADVCAP)   advcap_q   <= i_sw_wdata;
            if (sw_word == REG_ERR_MASK) err_mask_q <= i_sw_wdata;
        end
    end

    // Retrain request: cleared on entry into the Retrain state, ahead of any SW set
    always_ff @(posedge i_fdi_lclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= '0;
            retrain_q <= 1'b0;
        end else begin
            state_q <= i_fdi_pl_state_sts;
            if (retrain_entry) begin
                retrain_q <= 1'b0;
            end else if (sw_wr_ok && sw_word == REG_LINK_CTRL) begin
                retrain_q <= i_sw_wdata[RETRAIN_BIT];
            end
        end
    end

    // Saturating count of HW writes that land on no HW-writable register
    always_ff @(posedge i_fdi_lclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            drop_cnt_q <= '0;
        end else if (sw_wr_ok && sw_word == REG_DROP_CNT) begin
            drop_cnt_q <= CNT_W'(hw_drop);
        end else if (hw_drop && drop_cnt_q != DROP_CNT_MAX) begin
            drop_cnt_q <= drop_cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        rd_mux = '0;
        case (sw_word)
            REG_LINK_CTRL:  rd_mux = DATA_W'(retrain_q);
            REG_LINK_STS:   rd_mux = {link_sts_q, i_fdi_pl_state_sts};
            REG_UNCORR_STS: rd_mux = uncorr_q;
            REG_CORR_STS:   rd_mux = corr_q;
            REG_HDR_LOG:    rd_mux = hdr_log_q;
            REG_ADVCAP:     rd_mux = advcap_q;
            REG_ERR_MASK:   rd_mux = err_mask_q;
            REG_DROP_CNT:   rd_mux = DATA_W'(drop_cnt_q);
            default:        rd_mux = '0;
        endcase
    end

    // Read response, error pulse and interrupt
    always_ff @(posedge i_fdi_lclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            rvalid_q <= sw_rd_ok;
            if (sw_rd_ok) rdata_q <= rd_mux;
            err_q <= sw_conflict | ((i_sw_wr | i_sw_rd) & ~sw_addr_ok);
            irq_q <= |((uncorr_q | corr_q) & ~err_mask_q);
        end
    end

    assign o_sw_rdata                      = rdata_q;
    assign o_sw_rvalid                     = rvalid_q;
    assign o_sw_err                        = err_q;
    assign o_CSR_UCIe_Link_Control_Retrain = retrain_q;
    assign o_CSR_ADVCAP                    = advcap_q;
    assign o_irq                           = irq_q;

endmodule

// File: tb/tb_ucie_ctl_csr_regfile.sv
// Directed self-checking bench for ucie_ctl_csr_regfile.
module tb_ucie_ctl_csr_regfile;

    localparam logic [31:0] ADVCAP_RST = 32'hCAFE_0042;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_wr;
    logic [7:0]  a_addr;
    logic [31:0] a_wdata;
    logic [3:0]  pl_state;
    logic        sw_wr;
    logic        sw_rd;
    logic [7:0]  sw_addr;
    logic [31:0] sw_wdata;
    logic [31:0] sw_rdata;
    logic        sw_rvalid;
    logic        sw_err;
    logic        retrain;
    logic [31:0] advcap;
    logic        irq;

    int n_tests = 0;
    int n_fail  = 0;

    ucie_ctl_csr_regfile #(
        .ADVCAP_RST   (ADVCAP_RST),
        .ERR_MASK_RST (32'hFFFF_FFFF)
    ) dut (
        .i_fdi_lclk                      (clk),
        .i_rst_n                         (rst_n),
        .i_a_wr                          (a_wr),
        .i_a_addr                        (a_addr),
        .i_a_wdata                       (a_wdata),
        .i_fdi_pl_state_sts              (pl_state),
        .i_sw_wr                         (sw_wr),
        .i_sw_rd                         (sw_rd),
        .i_sw_addr                       (sw_addr),
        .i_sw_wdata                      (sw_wdata),
        .o_sw_rdata                      (sw_rdata),
        .o_sw_rvalid                     (sw_rvalid),
        .o_sw_err                        (sw_err),
        .o_CSR_UCIe_Link_Control_Retrain (retrain),
        .o_CSR_ADVCAP                    (advcap),
        .o_irq                           (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic hw_write(input logic [7:0] addr, input logic [31:0] data);
        a_wr = 1'b1; a_addr = addr; a_wdata = data;
        tick();
        a_wr = 1'b0;
    endtask

    task automatic sw_write(input logic [7:0] addr, input logic [31:0] data);
        sw_wr = 1'b1; sw_addr = addr; sw_wdata = data;
        tick();
        sw_wr = 1'b0;
    endtask

    task automatic sw_read(input logic [7:0] addr, input logic [31:0] exp, input string tag);
        sw_rd = 1'b1; sw_addr = addr;
        tick();
        sw_rd = 1'b0;
        check({tag, "_rvalid"}, 32'(sw_rvalid), 32'd1);
        check(tag, sw_rdata, exp);
    endtask

    initial begin
        rst_n = 1'b0; a_wr = 1'b0; a_addr = '0; a_wdata = '0; pl_state = 4'h0;
        sw_wr = 1'b0; sw_rd = 1'b0; sw_addr = '0; sw_wdata = '0;
        #12;
        check("rst_advcap",  advcap,            ADVCAP_RST);
        check("rst_irq",     32'(irq),          32'd0);
        check("rst_rvalid",  32'(sw_rvalid),    32'd0);
        check("rst_err",     32'(sw_err),       32'd0);
        check("rst_retrain", 32'(retrain),      32'd0);
        check("rst_rdata",   sw_rdata,          32'd0);
        rst_n = 1'b1;
        tick();

        sw_read(8'h14, ADVCAP_RST, "rd_advcap_rst");
        sw_read(8'h18, 32'hFFFF_FFFF, "rd_mask_rst");
        check("rdata_hold", sw_rdata, 32'hFFFF_FFFF);
        tick();
        check("rvalid_drop", 32'(sw_rvalid), 32'd0);
        check("rdata_hold2", sw_rdata, 32'hFFFF_FFFF);

        // Sticky OR-accumulation and masked interrupt
        hw_write(8'h08, 32'h5);
        hw_write(8'h08, 32'h2);
        sw_read(8'h08, 32'h7, "uncorr_or");
        check("irq_masked", 32'(irq), 32'd0);
        sw_write(8'h18, 32'h0);
        tick();
        check("irq_unmasked", 32'(irq), 32'd1);
        sw_write(8'h08, 32'h7);
        tick();
        check("irq_cleared", 32'(irq), 32'd0);
        sw_read(8'h08, 32'h0, "uncorr_w1c");

        // Set beats same-cycle RW1C; untouched bits survive
        hw_write(8'h0C, 32'h10);
        a_wr = 1'b1; a_addr = 8'h0C; a_wdata = 32'h2;
        sw_wr = 1'b1; sw_addr = 8'h0C; sw_wdata = 32'h2;
        tick();
        a_wr = 1'b0; sw_wr = 1'b0;
        sw_read(8'h0C, 32'h12, "corr_set_wins");
        check("irq_corr", 32'(irq), 32'd1);
        sw_write(8'h0C, 32'hFFFF_FFFF);
        sw_read(8'h0C, 32'h0, "corr_w1c_all");

        // Retrain request set by SW, cleared on Retrain entry
        sw_write(8'h00, 32'h1);
        check("retrain_set", 32'(retrain), 32'd1);
        sw_read(8'h00, 32'h1, "rd_link_ctrl");
        pl_state = 4'b1011;
        tick();
        check("retrain_hw_clr", 32'(retrain), 32'd0);
        pl_state = 4'h1;
        tick();
        pl_state = 4'b1011;
        sw_wr = 1'b1; sw_addr = 8'h00; sw_wdata = 32'h1;
        tick();
        sw_wr = 1'b0;
        check("retrain_clr_beats_set", 32'(retrain), 32'd0);
        pl_state = 4'h5;

        // LINK_STS low nibble is the live state; SW writes are dropped
        hw_write(8'h04, 32'hABCD_1230);
        sw_write(8'h04, 32'h1111_1111);
        sw_read(8'h04, 32'hABCD_1235, "link_sts_live");
        hw_write(8'h10, 32'hDEAD_BEEF);
        sw_read(8'h10, 32'hDEAD_BEEF, "hdr_log");

        // Bad address and rd+wr conflict
        sw_read(8'h40, 32'h0, "bad_addr_rdata");
        check("bad_addr_err", 32'(sw_err), 32'd1);
        tick();
        check("err_one_pulse", 32'(sw_err), 32'd0);
        sw_rd = 1'b1; sw_wr = 1'b1; sw_addr = 8'h14; sw_wdata = 32'h1234_5678;
        tick();
        sw_rd = 1'b0; sw_wr = 1'b0;
        check("conflict_err",    32'(sw_err),    32'd1);
        check("conflict_rvalid", 32'(sw_rvalid), 32'd0);
        check("conflict_advcap", advcap,         ADVCAP_RST);
        sw_write(8'h14, 32'h0000_BEEF);
        check("advcap_sw_wr", advcap, 32'h0000_BEEF);
        hw_write(8'h14, 32'hFFFF_0000);
        check("advcap_hw_ignored", advcap, 32'h0000_BEEF);

        // Drop counter: the HW write to ADVCAP above counted as one drop
        sw_read(8'h1C, 32'h1, "drop_cnt_advcap");
        sw_write(8'h1C, 32'h0);
        sw_read(8'h1C, 32'h0, "drop_cnt_clr");
        a_wr = 1'b1; a_addr = 8'h20; a_wdata = 32'h0;
        for (int i = 0; i < 300; i++) tick();
        a_wr = 1'b0;
        sw_read(8'h1C, 32'hFF, "drop_cnt_sat");
        a_wr = 1'b1; a_addr = 8'h20;
        sw_wr = 1'b1; sw_addr = 8'h1C; sw_wdata = 32'hFFFF_FFFF;
        tick();
        a_wr = 1'b0; sw_wr = 1'b0;
        sw_read(8'h1C, 32'h1, "drop_cnt_clr_and_drop");

        // Async reset while a read response is showing
        sw_rd = 1'b1; sw_addr = 8'h18;
        tick();
        sw_rd = 1'b0;
        check("pre_reset_rvalid", 32'(sw_rvalid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_rst_rvalid", 32'(sw_rvalid), 32'd0);
        check("async_rst_advcap", advcap, ADVCAP_RST);
        #2;
        rst_n = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
